// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: multi-cycle adder/subtractor that processes CHUNK bits per
// clock, LSB chunk first. The ready/valid handshake on both sides allows only
// one operation in flight at a time. The result and flags are published
// together on entry to DONE and then held.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// RUN   | adding one chunk per cycle, chunk index 0..N-1
// DONE  | out_valid high, result held until out_ready
module seq_addsub_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    // Guarded divisor so a bad CHUNK reports through the check below rather
    // than as a divide-by-zero during elaboration.
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int N          = WIDTH / CHUNK_SAFE;
    localparam int IDXW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    generate
        if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
            $error("seq_addsub_unit: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sub_q, sub_d;
    logic              sgn_q, sgn_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;

    // Chunk datapath signals
    int                base;
    logic [CHUNK-1:0]  a_c;
    logic [CHUNK-1:0]  b_c;
    logic [CHUNK:0]    csum;
    logic              msb_cin;
    logic [WIDTH-1:0]  res_next;

    // Add the current chunk; carry into the MSB is recovered from its sum bit.
    always_comb begin
        base     = int'(idx_q) * CHUNK;
        a_c      = a_q[base +: CHUNK];
        b_c      = b_q[base +: CHUNK];
        csum     = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
        msb_cin  = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ csum[CHUNK-1];
        res_next = res_q;
        res_next[base +: CHUNK] = csum[CHUNK-1:0];
    end

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sgn_d   = sgn_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B here, the +1 rides in on the carry.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{op_sub}};
                    sub_d   = op_sub;
                    sgn_d   = op_signed;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_next;
                carry_d = csum[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    s_d     = res_next;
                    cout_d  = csum[CHUNK];
                    if (sgn_q) begin
                        ovf_d = msb_cin ^ csum[CHUNK];
                    end else if (sub_q) begin
                        ovf_d = ~csum[CHUNK];
                    end else begin
                        ovf_d = csum[CHUNK];
                    end
                    zero_d  = (res_next == '0);
                    neg_d   = sgn_q & res_next[WIDTH-1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sgn_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sgn_q   <= sgn_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed bench for seq_addsub_unit at WIDTH=16, CHUNK=4.
module tb_seq_addsub_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        op_sub;
    logic        op_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;

    int n_checks;
    int n_fail;

    seq_addsub_unit #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .op_signed (op_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    // One complete transaction: accept, scramble inputs, wait, check, handshake out.
    task automatic test_one_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                               input logic sub, input logic sgn, input logic [15:0] es,
                               input logic ec, input logic eo, input logic ez, input logic en);
        int cyc;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        op_sub    = sub;
        op_signed = sgn;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        a         = ~ta;
        b         = 16'h5A5A;
        op_sub    = ~sub;
        op_signed = ~sgn;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want 4", name, cyc);
        end
        n_checks++;
        if ({s, cout, ovf, zero, neg} !== {es, ec, eo, ez, en}) begin
            n_fail++;
            $display("FAIL %s result: got s=%h c=%b o=%b z=%b n=%b want s=%h c=%b o=%b z=%b n=%b",
                     name, s, cout, ovf, zero, neg, es, ec, eo, ez, en);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s after handshake: got in_ready=%b out_valid=%b want 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({in_ready, out_valid, s, cout, ovf, zero, neg} !== {2'b10, 16'h0000, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset state: got in_ready=%b out_valid=%b s=%h c=%b o=%b z=%b n=%b want 1 0 0000 0 0 0 0",
                     in_ready, out_valid, s, cout, ovf, zero, neg);
        end
    endtask

    task automatic test_add();
        test_one_op("uadd_3_5",     16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
        test_one_op("sadd_m3_m5",   16'hFFFD, 16'hFFFB, 1'b0, 1'b1, 16'hFFF8, 1'b1, 1'b0, 1'b0, 1'b1);
        test_one_op("sadd_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        test_one_op("usub_8_2",     16'h0008, 16'h0002, 1'b1, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0);
        test_one_op("usub_2_8",     16'h0002, 16'h0008, 1'b1, 1'b0, 16'hFFFA, 1'b0, 1'b1, 1'b0, 1'b0);
        test_one_op("ssub_m4_m2",   16'hFFFC, 16'hFFFE, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        test_one_op("usub_equal",   16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_edges();
        test_one_op("uadd_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        test_one_op("ssub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        test_one_op("uadd_carries", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 16'h00F0;
        b         = 16'h000F;
        op_sub    = 1'b0;
        op_signed = 1'b0;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && cyc < 20) begin
            a = a + 16'h1111;
            b = b ^ 16'hFFFF;
            op_sub = ~op_sub;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL bp latency: got %0d want 4", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            a = 16'hABCD + 16'(i);
            b = 16'h1357;
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, s, cout, ovf, zero, neg} !== {2'b10, 16'h00FF, 4'b0000}) begin
                n_fail++;
                $display("FAIL bp hold %0d: got out_valid=%b in_ready=%b s=%h c=%b o=%b z=%b n=%b want 1 0 00ff 0 0 0 0",
                         i, out_valid, in_ready, s, cout, ovf, zero, neg);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, s} !== {2'b10, 16'h00FF}) begin
            n_fail++;
            $display("FAIL bp release: got in_ready=%b out_valid=%b s=%h want 1 0 00ff", in_ready, out_valid, s);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 16'h0011;
        b         = 16'h0022;
        op_sub    = 1'b0;
        op_signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, s, cout, ovf, zero, neg} !== {2'b10, 16'h0000, 4'b0000}) begin
            n_fail++;
            $display("FAIL midrun reset clear: got in_ready=%b out_valid=%b s=%h c=%b o=%b z=%b n=%b want 1 0 0000 0 0 0 0",
                     in_ready, out_valid, s, cout, ovf, zero, neg);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midrun no out_valid: got %0d valid cycles want 0", seen);
        end
        test_one_op("post_reset_1_1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        op_signed = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_edges();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
